// File: rtl/core_switch_pkg.sv
// Shared types and NMI widths for the runtime core switch.
package core_switch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

endpackage

// File: rtl/core_switch_timer.sv
// Loadable down-counter with zero flag; holds at zero, reloads to RST_VAL on reset.
module core_switch_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_switch_ctrl.sv
// Runtime core selector: one active core owns the NMI master port; switching drains, resets, releases.
// Optional drain timeout enabled by defining CORE_SWITCH_TIMEOUT_EN.
module core_switch_ctrl
  import core_switch_pkg::*;
#(
  parameter int NUM_CORES      = 2,
  parameter int SEL_W          = $clog2(NUM_CORES),
  parameter int DEF_CORE       = 0,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic [31:0]                 irq_i,
  input  logic [NUM_CORES-1:0]        core_valid_i,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata_i,
  input  logic [NUM_CORES*STRB_W-1:0] core_wstrb_i,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata_o,
  output logic [NUM_CORES-1:0]        core_ready_o,
  output logic [NUM_CORES*32-1:0]     core_irq_o,
  output logic [NUM_CORES-1:0]        core_rst_n_o,
  output logic                        mem_valid_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [STRB_W-1:0]           mem_wstrb_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic                        mem_ready_i,
  output logic [SEL_W-1:0]            active_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int MAX_CYC = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   act_q, act_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic               pend_q;
  logic               sel_valid;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               drain_done;

  core_switch_timer #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(RST_CYCLES - 1))
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Datapath: addresses/data always follow the active core; only valid, ready, irq and resets are gated by state.
  always_comb begin
    sel_valid    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wstrb_o  = '0;
    core_ready_o = '0;
    core_irq_o   = '0;
    core_rst_n_o = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (act_q == SEL_W'(i)) begin
        sel_valid   = core_valid_i[i];
        mem_addr_o  = core_addr_i[i*ADDR_W +: ADDR_W];
        mem_wdata_o = core_wdata_i[i*DATA_W +: DATA_W];
        mem_wstrb_o = core_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
    case (state_q)
      RUN:     mem_valid_o = sel_valid;
      DRAIN:   mem_valid_o = sel_valid & pend_q;
      default: mem_valid_o = 1'b0;
    endcase
    for (int i = 0; i < NUM_CORES; i++) begin
      if (act_q == SEL_W'(i)) begin
        core_rst_n_o[i] = (state_q != HOLD);
        if (state_q == RUN) begin
          core_ready_o[i]       = mem_ready_i;
          core_irq_o[i*32 +: 32] = irq_i;
        end else if (state_q == DRAIN) begin
          core_ready_o[i] = mem_ready_i & mem_valid_o;
        end
      end
    end
  end

  assign core_rdata_o = {NUM_CORES{mem_rdata_i}};
  assign drain_done   = ~pend_q | (mem_ready_i & mem_valid_o);

`ifdef CORE_SWITCH_TIMEOUT_EN
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    tgt_d    = tgt_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = CNT_W'(RST_CYCLES - 1);
`ifdef CORE_SWITCH_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      RUN: begin
        if ((sel_i != act_q) && (int'(sel_i) < NUM_CORES)) begin
          tgt_d   = sel_i;
          state_d = DRAIN;
`ifdef CORE_SWITCH_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      DRAIN: begin
        if (drain_done) begin
          act_d    = tgt_q;
          tmr_load = 1'b1;
          state_d  = HOLD;
`ifdef CORE_SWITCH_TIMEOUT_EN
        end else if (tmr_zero) begin
          act_d     = tgt_q;
          tmr_load  = 1'b1;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else begin
          tmr_dec = 1'b1;
`endif
        end
      end
      default: begin
        if (tmr_zero) begin
          state_d = RUN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      act_q   <= SEL_W'(DEF_CORE);
      tgt_q   <= SEL_W'(DEF_CORE);
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tgt_q   <= tgt_d;
      pend_q  <= mem_valid_o & ~mem_ready_i;
    end
  end

`ifdef CORE_SWITCH_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign active_o = act_q;
  assign busy_o   = (state_q != RUN);

endmodule
